// File: rtl/mul_responder_pkg.sv
// Shared types and widths for the shift-add multiplier responder.
// The optional start_err pulse is enabled with MUL_RESPONDER_START_ERR_EN.
package mul_responder_pkg;

  localparam int OP_W  = 8;
  localparam int RES_W = 16;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_responder_dp.sv
// Shift-add datapath: operand registers, 16-bit accumulator and bit counter.
// Independent of MUL_RESPONDER_START_ERR_EN.
module mul_responder_dp
  import mul_responder_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [OP_W-1:0]  op_a,
  input  logic [OP_W-1:0]  op_b,
  output logic [RES_W-1:0] acc,
  output logic             last
);

  logic [OP_W-1:0]  a_q;
  logic [OP_W-1:0]  b_q;
  logic [CNT_W-1:0] cnt;
  logic [RES_W-1:0] addend;

  // One multiplier bit per step, LSB first; the multiplicand is weighted by the bit index.
  always_comb begin
    addend = '0;
    if (b_q[cnt])
      addend = RES_W'(a_q) << cnt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (load) begin
      a_q <= op_a;
      b_q <= op_b;
      acc <= '0;
      cnt <= '0;
    end else if (step) begin
      acc <= acc + addend;
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_W'(OP_W - 1));

endmodule

// File: rtl/mul_responder.sv
// Multiplier responder: FSM and sequencer handshake around the shift-add datapath.
// Define MUL_RESPONDER_START_ERR_EN to flag starts that arrive while a job is in progress.
module mul_responder
  import mul_responder_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OP_W-1:0]  op_a,
  input  logic [OP_W-1:0]  op_b,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] result,
  output logic             start_err
);

  state_t           state;
  state_t           next_state;
  logic             accept;
  logic             last;
  logic [RES_W-1:0] acc;
  logic             busy_d;
  logic             done_d;

  assign accept = (state == IDLE) && start;

  mul_responder_dp u_dp (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .step  (state == RUN),
    .op_a  (op_a),
    .op_b  (op_b),
    .acc   (acc),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (!reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last)  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered, so done appears the cycle after DONE and busy spans it.
  always_comb begin
    busy_d = (next_state != IDLE) || (state == DONE);
    done_d = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      busy <= busy_d;
      done <= done_d;
      if (done_d)
        result <= acc;
    end
  end

`ifdef MUL_RESPONDER_START_ERR_EN
  always_ff @(posedge clk) begin
    if (!reset)
      start_err <= 1'b0;
    else
      start_err <= start && (state != IDLE);
  end
`else
  assign start_err = 1'b0;
`endif

endmodule

// File: tb/tb_mul_responder.sv
// Self-checking bench for mul_responder using a job-timeline reference model.
// Honours MUL_RESPONDER_START_ERR_EN for the expected start_err behaviour.
module tb_mul_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        start_err;

  int total = 0;
  int bad   = 0;

  int          edge_n = 0;
  int          job_e  = -1;
  logic [15:0] job_p  = '0;
  logic [15:0] exp_result = '0;
  logic        exp_busy = 1'b0;
  logic        exp_done = 1'b0;
  logic        exp_err  = 1'b0;
  int          done_seen = 0;
  int          err_seen  = 0;
  int          exp_err_total;
  logic [7:0]  a0;
  logic [7:0]  b0;

  always #5 clk = ~clk;

  mul_responder dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .start_err (start_err)
  );

  // A job accepted at edge e is busy through e..e+9 and reports its product at e+9.
  task automatic model_step(input logic s, input logic [7:0] a, input logic [7:0] b, input logic r);
    logic in_prog;
    edge_n++;
    if (!r) begin
      job_e      = -1;
      exp_result = '0;
      exp_busy   = 1'b0;
      exp_done   = 1'b0;
      exp_err    = 1'b0;
      return;
    end
    in_prog = (job_e >= 0) && (edge_n > job_e) && (edge_n <= job_e + 9);
    if (s && !in_prog) begin
      job_e = edge_n;
      job_p = 16'(a) * 16'(b);
    end
`ifdef MUL_RESPONDER_START_ERR_EN
    exp_err = s && in_prog;
`else
    exp_err = 1'b0;
`endif
    exp_done = (job_e >= 0) && (edge_n == job_e + 9);
    if (exp_done)
      exp_result = job_p;
    exp_busy = (job_e >= 0) && (edge_n >= job_e) && (edge_n <= job_e + 9);
  endtask

  task automatic checkOutput();
    total++;
    assert (busy === exp_busy) else begin
      bad++;
      $error("[TB] FAIL busy edge=%0d observed=%b expected=%b", edge_n, busy, exp_busy);
    end
    total++;
    assert (done === exp_done) else begin
      bad++;
      $error("[TB] FAIL done edge=%0d observed=%b expected=%b", edge_n, done, exp_done);
    end
    total++;
    assert (result === exp_result) else begin
      bad++;
      $error("[TB] FAIL result edge=%0d observed=%0d expected=%0d", edge_n, result, exp_result);
    end
    total++;
    assert (start_err === exp_err) else begin
      bad++;
      $error("[TB] FAIL start_err edge=%0d observed=%b expected=%b", edge_n, start_err, exp_err);
    end
    if (done === 1'b1) done_seen++;
    if (start_err === 1'b1) err_seen++;
  endtask

  task automatic check_value(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic r, input logic [7:0] a, input logic [7:0] b);
    start = s;
    reset = r;
    op_a  = a;
    op_b  = b;
    @(posedge clk);
    model_step(s, a, b, r);
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b1, 8'($urandom), 8'($urandom));
  endtask

  initial begin
    logic [7:0]  sweep_a [4];
    logic [7:0]  sweep_b [4];
    logic [15:0] sweep_p [4];
    sweep_a = '{8'd255, 8'd0,  8'd200, 8'd1};
    sweep_b = '{8'd255, 8'd77, 8'd1,   8'd128};
    sweep_p = '{16'd65025, 16'd0, 16'd200, 16'd128};

    reset = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;

    $display("[TB] reset");
    applyStimulus(1'b0, 1'b0, 8'd0, 8'd0);
    applyStimulus(1'b0, 1'b0, 8'd0, 8'd0);
    check_value("reset_busy", 16'(busy), 16'd0);
    check_value("reset_result", result, 16'd0);
    idle(2);

    $display("[TB] 13x11 latency");
    done_seen = 0;
    applyStimulus(1'b1, 1'b1, 8'd13, 8'd11);
    check_value("busy_after_start", 16'(busy), 16'd1);
    idle(8);
    check_value("done_before_e9", 16'(done), 16'd0);
    idle(1);
    check_value("done_at_e9", 16'(done), 16'd1);
    check_value("result_13x11", result, 16'd143);
    idle(1);
    check_value("done_at_e10", 16'(done), 16'd0);
    check_value("busy_at_e10", 16'(busy), 16'd0);
    check_value("done_count_13x11", 16'(done_seen), 16'd1);

    $display("[TB] operand sweep");
    for (int k = 0; k < 4; k++) begin
      done_seen = 0;
      applyStimulus(1'b1, 1'b1, sweep_a[k], sweep_b[k]);
      idle(11);
      check_value("sweep_result", result, sweep_p[k]);
      check_value("sweep_done_count", 16'(done_seen), 16'd1);
    end

    $display("[TB] start held 12 cycles");
    done_seen = 0;
    err_seen  = 0;
    for (int i = 0; i < 12; i++)
      applyStimulus(1'b1, 1'b1, 8'($urandom), 8'($urandom));
    idle(12);
`ifdef MUL_RESPONDER_START_ERR_EN
    exp_err_total = 10;
`else
    exp_err_total = 0;
`endif
    check_value("held_done_count", 16'(done_seen), 16'd2);
    check_value("held_err_count", 16'(err_seen), 16'(exp_err_total));

    $display("[TB] reset mid-run");
    applyStimulus(1'b1, 1'b1, 8'($urandom), 8'($urandom));
    idle(3);
    applyStimulus(1'b0, 1'b0, 8'($urandom), 8'($urandom));
    check_value("midrun_busy", 16'(busy), 16'd0);
    check_value("midrun_done", 16'(done), 16'd0);
    check_value("midrun_result", result, 16'd0);
    done_seen = 0;
    idle(12);
    check_value("midrun_no_done", 16'(done_seen), 16'd0);
    applyStimulus(1'b1, 1'b1, 8'd7, 8'd9);
    idle(10);
    check_value("result_7x9", result, 16'd63);

    $display("[TB] operands change during run");
    a0 = 8'($urandom);
    b0 = 8'($urandom);
    applyStimulus(1'b1, 1'b1, a0, b0);
    idle(10);
    check_value("latched_product", result, 16'(a0) * 16'(b0));

    $display("[TB] reset and start same edge");
    applyStimulus(1'b1, 1'b0, 8'd5, 8'd5);
    check_value("rst_start_busy", 16'(busy), 16'd0);
    idle(1);
    check_value("rst_start_busy_next", 16'(busy), 16'd0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 49) != 0),
                    8'($urandom), 8'($urandom));
    idle(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
